// File: rtl/ts_ram_pingpong_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the TS RAM ping-pong write scheduler.
package ts_ram_pingpong_ctrl_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int unsigned TS_PKT_WORDS = 47;
  localparam int unsigned CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2,
    ST_CLOSE = 2'd3
  } state_e;

  // Saturating increment for the drop/error statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ts_ram_pingpong_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single level signal crossing into the TS clock domain.
module ts_ram_pingpong_ctrl_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the asynchronous level through two stages.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Synchroniser stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/ts_ram_pingpong_ctrl.sv
// Write-side scheduler placing whole TS packets into alternating PCIe ping-pong RAM banks.
module ts_ram_pingpong_ctrl
  import ts_ram_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned PKT_WORDS     = TS_PKT_WORDS,
  parameter int unsigned PKTS_PER_BANK = 16,
  parameter int unsigned ADDR_W        = 10
) (
  input  logic              clk_ts,
  input  logic              rst_ts,
  input  logic [31:0]       pkt_din,
  input  logic              pkt_din_en,
  input  logic              flush_req,
  input  logic              ram_full_1,
  input  logic              ram_full_2,
  output logic              ts_ram_wr,
  output logic [31:0]       ts_ram_wdata,
  output logic [ADDR_W-1:0] ts_ram_addr,
  output logic              ts_ram_sel,
  output logic              bank_done_1,
  output logic              bank_done_2,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned WCNT_W = $clog2(PKT_WORDS + 1);
  localparam int unsigned PCNT_W = $clog2(PKTS_PER_BANK + 1);
  localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(PKT_WORDS);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PKTS_PER_BANK - 1);

  state_e state_q, state_d;

  logic              en_prev_q, en_prev_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              flush_q, flush_d;
  logic              sel_q, sel_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_1_q, done_1_d;
  logic              done_2_q, done_2_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic full_1_s, full_2_s;
  logic start_c, sync_ok_c, full_cur_c, flush_hit_c, flush_any_c, words_full_c;

  ts_ram_pingpong_ctrl_sync_2ff u_sync_full_1 (
    .clk   (clk_ts),
    .rst   (rst_ts),
    .d_in  (ram_full_1),
    .q_out (full_1_s)
  );

  ts_ram_pingpong_ctrl_sync_2ff u_sync_full_2 (
    .clk   (clk_ts),
    .rst   (rst_ts),
    .d_in  (ram_full_2),
    .q_out (full_2_s)
  );

  assign start_c      = pkt_din_en & ~en_prev_q;
  assign sync_ok_c    = (pkt_din[31:24] == TS_SYNC_BYTE);
  assign full_cur_c   = sel_q ? full_2_s : full_1_s;
  // Flush only counts once the current bank holds at least one packet.
  assign flush_hit_c  = flush_req & (pcnt_q != '0);
  assign flush_any_c  = flush_q | flush_hit_c;
  assign words_full_c = (wcnt_q == WCNT_FULL);

  // State register.
  always_ff @(posedge clk_ts) begin
    if (rst_ts) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decision; packet end of any kind honours a pending flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c)          state_d = (full_cur_c || !sync_ok_c) ? ST_DROP : ST_WRITE;
        else if (flush_hit_c) state_d = ST_CLOSE;
      end
      ST_WRITE: begin
        if (pkt_din_en) begin
          if (words_full_c) state_d = ST_DROP;
        end else if (flush_any_c || (words_full_c && (pcnt_q == PCNT_LAST))) begin
          state_d = ST_CLOSE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!pkt_din_en) state_d = flush_any_c ? ST_CLOSE : ST_IDLE;
      end
      ST_CLOSE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values: writes, pointer rewind, counters, bank hand-over.
  always_comb begin
    en_prev_d  = pkt_din_en;
    ptr_d      = ptr_q;
    base_d     = base_q;
    wcnt_d     = wcnt_q;
    pcnt_d     = pcnt_q;
    flush_d    = flush_q;
    sel_d      = sel_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    done_1_d   = 1'b0;
    done_2_d   = 1'b0;
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          flush_d = flush_any_c;
          if (full_cur_c) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else if (!sync_ok_c) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end else begin
            wr_d    = 1'b1;
            wdata_d = pkt_din;
            addr_d  = ptr_q;
            ptr_d   = ptr_q + ADDR_W'(1);
            wcnt_d  = WCNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        flush_d = flush_any_c;
        if (pkt_din_en) begin
          if (!words_full_c) begin
            wr_d    = 1'b1;
            wdata_d = pkt_din;
            addr_d  = ptr_q;
            ptr_d   = ptr_q + ADDR_W'(1);
            wcnt_d  = wcnt_q + WCNT_W'(1);
          end else begin
            ptr_d     = base_q;
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end else if (words_full_c) begin
          pcnt_d = pcnt_q + PCNT_W'(1);
          base_d = ptr_q;
        end else begin
          ptr_d     = base_q;
          err_cnt_d = sat_inc(err_cnt_q);
        end
      end
      ST_DROP: begin
        flush_d = flush_any_c;
      end
      ST_CLOSE: begin
        sel_d   = ~sel_q;
        ptr_d   = '0;
        base_d  = '0;
        pcnt_d  = '0;
        wcnt_d  = '0;
        flush_d = 1'b0;
      end
      default: ;
    endcase
    if (state_d == ST_CLOSE) begin
      done_1_d = ~sel_q;
      done_2_d = sel_q;
    end
  end

  // Datapath and output registers; en_prev resets high so a packet in flight is not restarted.
  always_ff @(posedge clk_ts) begin
    if (rst_ts) begin
      en_prev_q  <= 1'b1;
      ptr_q      <= '0;
      base_q     <= '0;
      wcnt_q     <= '0;
      pcnt_q     <= '0;
      flush_q    <= 1'b0;
      sel_q      <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= '0;
      done_1_q   <= 1'b0;
      done_2_q   <= 1'b0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      en_prev_q  <= en_prev_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      wcnt_q     <= wcnt_d;
      pcnt_q     <= pcnt_d;
      flush_q    <= flush_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      done_1_q   <= done_1_d;
      done_2_q   <= done_2_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ts_ram_wr    = wr_q;
  assign ts_ram_wdata = wdata_q;
  assign ts_ram_addr  = addr_q;
  assign ts_ram_sel   = sel_q;
  assign bank_done_1  = done_1_q;
  assign bank_done_2  = done_2_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ts_ram_pingpong_ctrl.sv
// Self-checking bench: packet-level reference model predicts every write and bank close per cycle.
module tb_ts_ram_pingpong_ctrl;

  localparam int PW  = 47;
  localparam int PPB = 16;

  logic        clk_ts = 1'b0;
  logic        rst_ts;
  logic [31:0] pkt_din;
  logic        pkt_din_en;
  logic        flush_req;
  logic        ram_full_1;
  logic        ram_full_2;
  logic        ts_ram_wr;
  logic [31:0] ts_ram_wdata;
  logic [9:0]  ts_ram_addr;
  logic        ts_ram_sel;
  logic        bank_done_1;
  logic        bank_done_2;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  ts_ram_pingpong_ctrl #(.PKT_WORDS(PW), .PKTS_PER_BANK(PPB), .ADDR_W(10)) dut (
    .clk_ts       (clk_ts),
    .rst_ts       (rst_ts),
    .pkt_din      (pkt_din),
    .pkt_din_en   (pkt_din_en),
    .flush_req    (flush_req),
    .ram_full_1   (ram_full_1),
    .ram_full_2   (ram_full_2),
    .ts_ram_wr    (ts_ram_wr),
    .ts_ram_wdata (ts_ram_wdata),
    .ts_ram_addr  (ts_ram_addr),
    .ts_ram_sel   (ts_ram_sel),
    .bank_done_1  (bank_done_1),
    .bank_done_2  (bank_done_2),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk_ts = ~clk_ts;

  int cyc = 0;
  always @(posedge clk_ts) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Expected writes {sel, addr, data} and bank closes (1 or 2), keyed by output cycle.
  logic [42:0] exp_wr [int];
  int          exp_done [int];

  // Reference model state, packet granularity.
  int m_sel, m_cnt, m_pend, m_drop, m_err;

  // Observation of DUT activity for the literal spot checks.
  int obs_wr = 0, obs_d1 = 0, obs_d2 = 0;
  int obs_last_addr = 0, obs_burst_addr = 0, obs_burst_sel = 0;
  bit prev_wr = 1'b0;

  bit         ew;
  int         ed;
  logic [1:0] want_done;

  // Per-cycle compare of write strobe/payload and bank-done pulses.
  always @(negedge clk_ts) begin
    if (chk_en) begin
      ew = exp_wr.exists(cyc);
      checks++;
      if (ts_ram_wr !== ew) begin
        failures++;
        $display("FAIL wr_strobe cyc=%0d got=%b want=%b", cyc, ts_ram_wr, ew);
      end else if (ew && ({ts_ram_sel, ts_ram_addr, ts_ram_wdata} !== exp_wr[cyc])) begin
        failures++;
        $display("FAIL wr_payload cyc=%0d got sel=%b addr=%0d data=%h want sel=%b addr=%0d data=%h",
                 cyc, ts_ram_sel, ts_ram_addr, ts_ram_wdata,
                 exp_wr[cyc][42], exp_wr[cyc][41:32], exp_wr[cyc][31:0]);
      end
      ed = exp_done.exists(cyc) ? exp_done[cyc] : 0;
      want_done = {ed == 2, ed == 1};
      checks++;
      if ({bank_done_2, bank_done_1} !== want_done) begin
        failures++;
        $display("FAIL bank_done cyc=%0d got=%b want=%b", cyc, {bank_done_2, bank_done_1}, want_done);
      end
      if (ts_ram_wr === 1'b1) begin
        obs_wr++;
        obs_last_addr = int'(ts_ram_addr);
        if (!prev_wr) begin
          obs_burst_addr = int'(ts_ram_addr);
          obs_burst_sel  = int'(ts_ram_sel);
        end
      end
      prev_wr = (ts_ram_wr === 1'b1);
      if (bank_done_1 === 1'b1) obs_d1++;
      if (bank_done_2 === 1'b1) obs_d2++;
    end
  end

  task automatic tick();
    @(posedge clk_ts);
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_cnt = 0; m_pend = 0; m_drop = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst_ts = 1'b1; pkt_din_en = 1'b0; flush_req = 1'b0;
    tick(); tick();
    rst_ts = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic set_full(input bit f1, input bit f2);
    ram_full_1 = f1;
    ram_full_2 = f2;
    repeat (4) tick();
  endtask

  function automatic logic [31:0] good_w0();
    logic [23:0] r;
    r = 24'($urandom);
    return {8'h47, r};
  endfunction

  // Drive one packet and record what the model says must be written / closed.
  task automatic send_pkt(input int n, input logic [31:0] w0, input int flush_at,
                          input int rst_at, input int full_at);
    int k0, bank, base;
    bit wr_ok;
    k0    = cyc + 1;
    bank  = m_sel;
    base  = m_cnt * PW;
    wr_ok = 1'b0;
    if ((m_sel == 0) ? ram_full_1 : ram_full_2) m_drop++;
    else if (w0[31:24] != 8'h47)               m_err++;
    else                                        wr_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = (i == 0) ? w0 : $urandom;
      pkt_din    = w;
      pkt_din_en = 1'b1;
      flush_req  = (i == flush_at);
      if (i == full_at) begin
        if (bank == 0) ram_full_1 = 1'b1;
        else           ram_full_2 = 1'b1;
      end
      if (i == rst_at) begin
        rst_ts = 1'b1;
        tick();
        pkt_din_en = 1'b0;
        flush_req  = 1'b0;
        tick();
        rst_ts = 1'b0;
        model_reset();
        return;
      end
      if (i == flush_at && m_cnt > 0) m_pend = 1;
      if (wr_ok && i < PW) exp_wr[cyc + 1] = {bank[0], 10'(base + i), w};
      tick();
    end
    pkt_din_en = 1'b0;
    flush_req  = 1'b0;
    if (wr_ok && n != PW) m_err++;
    else if (wr_ok)       m_cnt++;
    if (m_pend != 0 || m_cnt == PPB) begin
      exp_done[k0 + n] = bank + 1;
      m_sel  = 1 - m_sel;
      m_cnt  = 0;
      m_pend = 0;
    end
    tick();
  endtask

  // Inter-packet gap, optionally with a flush pulse while idle; then check the counters.
  task automatic gap(input int g, input bit fl);
    if (fl) begin
      flush_req = 1'b1;
      if (m_cnt > 0) begin
        exp_done[cyc + 1] = m_sel + 1;
        m_sel = 1 - m_sel;
        m_cnt = 0;
      end
      tick();
      flush_req = 1'b0;
    end
    repeat (g) tick();
    check_val("drop_cnt", int'(drop_cnt), m_drop);
    check_val("err_cnt", int'(err_cnt), m_err);
  endtask

  task automatic good_pkt();
    send_pkt(PW, good_w0(), -1, -1, -1);
    gap(2, 1'b0);
  endtask

  int s_wr, s_d1, s_d2;

  initial begin
    rst_ts = 1'b1; pkt_din = '0; pkt_din_en = 1'b0; flush_req = 1'b0;
    ram_full_1 = 1'b0; ram_full_2 = 1'b0;
    model_reset();
    repeat (3) tick();
    check_val("rst_wr", int'(ts_ram_wr), 0);
    check_val("rst_addr", int'(ts_ram_addr), 0);
    check_val("rst_sel", int'(ts_ram_sel), 0);
    check_val("rst_done", int'({bank_done_2, bank_done_1}), 0);
    check_val("rst_drop", int'(drop_cnt), 0);
    check_val("rst_err", int'(err_cnt), 0);
    chk_en = 1'b1;
    rst_ts = 1'b0;
    tick();

    // 16 good packets fill bank 1, 17th lands in bank 2 at 0.
    s_wr = obs_wr; s_d1 = obs_d1;
    repeat (PPB) good_pkt();
    check_val("fill_writes", obs_wr - s_wr, 752);
    check_val("fill_last_addr", obs_last_addr, 751);
    check_val("fill_done1", obs_d1 - s_d1, 1);
    check_val("fill_sel", int'(ts_ram_sel), 1);
    good_pkt();
    check_val("pkt17_addr", obs_burst_addr, 0);
    check_val("pkt17_sel", obs_burst_sel, 1);

    // Full bank 1 at packet start drops it.
    do_reset();
    set_full(1'b1, 1'b0);
    s_wr = obs_wr;
    good_pkt();
    check_val("full_drop_cnt", int'(drop_cnt), 1);
    check_val("full_no_writes", obs_wr - s_wr, 0);
    set_full(1'b0, 1'b0);
    good_pkt();
    check_val("after_full_addr", obs_burst_addr, 0);

    // Bad sync byte.
    do_reset();
    s_wr = obs_wr;
    send_pkt(PW, 32'h0000_0002, -1, -1, -1);
    gap(2, 1'b0);
    check_val("badsync_err", int'(err_cnt), 1);
    check_val("badsync_no_writes", obs_wr - s_wr, 0);

    // Short packet is rewound over.
    do_reset();
    repeat (3) good_pkt();
    send_pkt(20, good_w0(), -1, -1, -1);
    gap(2, 1'b0);
    good_pkt();
    check_val("short_err", int'(err_cnt), 1);
    check_val("short_next_first", obs_burst_addr, 141);
    check_val("short_next_last", obs_last_addr, 187);

    // Idle flush, then flush latched mid-packet in bank 2.
    do_reset();
    repeat (3) good_pkt();
    s_d1 = obs_d1; s_d2 = obs_d2;
    gap(2, 1'b1);
    check_val("flush_done1", obs_d1 - s_d1, 1);
    check_val("flush_sel", int'(ts_ram_sel), 1);
    repeat (3) good_pkt();
    send_pkt(PW, good_w0(), 10, -1, -1);
    gap(2, 1'b0);
    check_val("flush_mid_done2", obs_d2 - s_d2, 1);
    check_val("flush_mid_sel", int'(ts_ram_sel), 0);

    // Reset on word 20 of a packet.
    do_reset();
    good_pkt();
    send_pkt(PW, good_w0(), -1, 20, -1);
    check_val("midrst_wr", int'(ts_ram_wr), 0);
    check_val("midrst_addr", int'(ts_ram_addr), 0);
    check_val("midrst_sel", int'(ts_ram_sel), 0);
    check_val("midrst_wdata_zero", int'(ts_ram_wdata == 32'h0), 1);
    gap(2, 1'b0);
    good_pkt();
    check_val("midrst_next_addr", obs_burst_addr, 0);
    check_val("midrst_next_sel", obs_burst_sel, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int p = 0; p < 160; p++) begin
      int kind, n, fa, fu;
      logic [31:0] w0;
      logic [7:0]  sb;
      kind = $urandom_range(0, 19);
      n = PW;
      w0 = good_w0();
      if (kind == 13)      n = $urandom_range(1, PW - 1);
      else if (kind == 14) n = $urandom_range(PW + 1, PW + 5);
      else if (kind == 15) begin
        n  = $urandom_range(1, PW);
        sb = 8'($urandom_range(0, 255));
        if (sb == 8'h47) sb = 8'h48;
        w0 = {sb, 24'($urandom)};
      end
      fa = (n >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
      fu = (n >= 2 && $urandom_range(0, 14) == 0) ? $urandom_range(1, n - 1) : -1;
      send_pkt(n, w0, fa, -1, fu);
      gap($urandom_range(1, 3), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 5) == 0 || fu >= 0)
        set_full(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
